shift_reg_univ: RTL

- Parametrised universal register, the successor to the single-bit D flip-flop.
- WIDTH bits wide, with synchronous active-high reset, clock enable, parallel load, logical shift left/right with serial inputs, and rotate left/right.
- Tracks shifts since the last load, so it also serves as a parallel-to-serial or serial-to-parallel converter in later lab exercises.

---
 rtl/shift_reg_univ.sv | 100 ++++++++++
 1 files changed

// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load, shift/rotate both ways, and a
// saturating count of shifts since the last load for serdes-style use.
module shift_reg_univ #(
  parameter int unsigned WIDTH   = 8,
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin_l,
  input  logic                       sin_r,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_l,
  output logic                       sout_r,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       drained
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROTL = 3'b011;
  localparam logic [2:0] MODE_ROTR = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  localparam logic [WIDTH-1:0] R_INIT = WIDTH'(RST_VAL);
  localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_shift;

  // Next-state selection; reserved modes fall through to hold.
  always_comb begin
    w_q_nxt = r_q;
    w_shift = 1'b0;
    case (mode)
      MODE_HOLD: w_q_nxt = r_q;
      MODE_SHL: begin
        w_q_nxt = {r_q[WIDTH-2:0], sin_l};
        w_shift = 1'b1;
      end
      MODE_SHR: begin
        w_q_nxt = {sin_r, r_q[WIDTH-1:1]};
        w_shift = 1'b1;
      end
      MODE_ROTL: begin
        w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_shift = 1'b1;
      end
      MODE_ROTR: begin
        w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
        w_shift = 1'b1;
      end
      MODE_LOAD: w_q_nxt = d;
      default:   w_q_nxt = r_q;
    endcase
  end

  // Counter clears on load and saturates at WIDTH.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (mode == MODE_LOAD) begin
      w_cnt_nxt = '0;
    end else if (w_shift && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= R_INIT;
      r_cnt <= '0;
    end else if (en) begin
      r_q   <= w_q_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign q       = r_q;
  assign cnt     = r_cnt;
  assign sout_l  = r_q[WIDTH-1];
  assign sout_r  = r_q[0];
  assign drained = (r_cnt == CNT_MAX);

  // Reserved encodings are legal (they hold) but almost certainly a caller bug.
  always_ff @(posedge clk) begin
    if (!rst && en) begin
      assert (mode[2:1] != 2'b11)
        else $warning("shift_reg_univ: reserved mode %b treated as HOLD", mode);
    end
  end

endmodule
